// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback sources.
// Optional REGFILE_CLEAR_EN adds a post-reset sequence that zeroes all 32 registers.
module regfile_write_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic               init_done,
    output logic               pend_valid
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

`ifdef REGFILE_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_RUN;
`endif

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rf_we_d;
    logic [AW-1:0]   rf_wa_d;
    logic [DW-1:0]   rf_wd_d;
    logic            accept_c;
    logic            arb_hit_c;
    logic [PW:0]     arb_idx_c;
    logic [PW-1:0]   win_c;
    logic [NREQ-1:0] grant_c;
    logic [AW-1:0]   win_addr_c;
    logic [DW-1:0]   win_data_c;
`ifdef REGFILE_CLEAR_EN
    logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
`endif

    assign accept_c   = (state_q == ST_RUN) && !rst;
    assign req_ready  = grant_c;
    assign pend_valid = rf_we;
`ifdef REGFILE_CLEAR_EN
    assign init_done  = (state_q == ST_RUN);
`else
    assign init_done  = !rst;
`endif

    // First valid requester found scanning upward from the pointer, wrapping modulo NREQ.
    always_comb begin
        grant_c    = '0;
        win_c      = '0;
        win_addr_c = '0;
        win_data_c = '0;
        arb_hit_c  = 1'b0;
        arb_idx_c  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_idx_c = {1'b0, ptr_q} + (PW+1)'(k);
            if (arb_idx_c >= (PW+1)'(NREQ)) begin
                arb_idx_c = arb_idx_c - (PW+1)'(NREQ);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept_c && !arb_hit_c && req_valid[i] && (arb_idx_c == (PW+1)'(i))) begin
                    arb_hit_c  = 1'b1;
                    grant_c[i] = 1'b1;
                    win_c      = PW'(i);
                    win_addr_c = req_addr[i*AW +: AW];
                    win_data_c = req_data[i*DW +: DW];
                end
            end
        end
    end

    // Next state, pointer and write-port values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa;
        rf_wd_d = rf_wd;
`ifdef REGFILE_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef REGFILE_CLEAR_EN
                // Leave once the write of the last register is on the port.
                if (rf_we && (rf_wa == AW'(31))) begin
                    state_d = ST_RUN;
                end else begin
                    rf_we_d   = 1'b1;
                    rf_wa_d   = AW'(clr_cnt_q);
                    rf_wd_d   = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
`else
                state_d = ST_RUN;
`endif
            end
            default: begin
                if (arb_hit_c) begin
                    ptr_d = (win_c == PW'(NREQ - 1)) ? '0 : win_c + 1'b1;
                    // Register 0 is hardwired to zero: accept the request but suppress the write.
                    if (win_addr_c != '0) begin
                        rf_we_d = 1'b1;
                        rf_wa_d = win_addr_c;
                        rf_wd_d = win_data_c;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
`ifdef REGFILE_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rf_we   <= rf_we_d;
            rf_wa   <= rf_wa_d;
            rf_wd   <= rf_wd_d;
`ifdef REGFILE_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, hand sequences and a random run against a round-robin model.
module tb_regfile_write_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rf_we;
    logic [AW-1:0]      rf_wa;
    logic [DW-1:0]      rf_wd;
    logic               init_done;
    logic               pend_valid;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .init_done(init_done), .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t tbl[14];

    // Random-run model state: pending request per requester and the expected port contents.
    bit              pv[NREQ];
    logic [AW-1:0]   pa[NREQ];
    logic [DW-1:0]   pd[NREQ];
    int              waitc[NREQ];
    int              ptr_m;
    logic            exp_we;
    logic [AW-1:0]   exp_wa;
    logic [DW-1:0]   exp_wd;

    initial begin
        // Rows: inputs this cycle, expected grant this cycle, expected port (from previous row's transfer).
        tbl[0]  = '{2'b10, 5'd0, 5'd10, 32'h0,  32'h1010,     2'b10, 1'b0, 5'd0,  32'h0};
        tbl[1]  = '{2'b01, 5'd3, 5'd0,  32'h11, 32'h0,        2'b01, 1'b1, 5'd10, 32'h1010};
        tbl[2]  = '{2'b00, 5'd0, 5'd0,  32'h0,  32'h0,        2'b00, 1'b1, 5'd3,  32'h11};
        tbl[3]  = '{2'b11, 5'd1, 5'd2,  32'hA,  32'hB,        2'b10, 1'b0, 5'd0,  32'h0};
        tbl[4]  = '{2'b11, 5'd1, 5'd2,  32'hA,  32'hB,        2'b01, 1'b1, 5'd2,  32'hB};
        tbl[5]  = '{2'b11, 5'd1, 5'd2,  32'hA,  32'hB,        2'b10, 1'b1, 5'd1,  32'hA};
        tbl[6]  = '{2'b11, 5'd1, 5'd2,  32'hA,  32'hB,        2'b01, 1'b1, 5'd2,  32'hB};
        tbl[7]  = '{2'b00, 5'd0, 5'd0,  32'h0,  32'h0,        2'b00, 1'b1, 5'd1,  32'hA};
        tbl[8]  = '{2'b10, 5'd0, 5'd0,  32'h0,  32'hFFFFFFFF, 2'b10, 1'b0, 5'd0,  32'h0};
        tbl[9]  = '{2'b00, 5'd0, 5'd0,  32'h0,  32'h0,        2'b00, 1'b0, 5'd0,  32'h0};
        tbl[10] = '{2'b11, 5'd4, 5'd9,  32'h44, 32'h99,       2'b01, 1'b0, 5'd0,  32'h0};
        tbl[11] = '{2'b10, 5'd4, 5'd9,  32'h44, 32'h99,       2'b10, 1'b1, 5'd4,  32'h44};
        tbl[12] = '{2'b00, 5'd0, 5'd0,  32'h0,  32'h0,        2'b00, 1'b1, 5'd9,  32'h99};
        tbl[13] = '{2'b00, 5'd0, 5'd0,  32'h0,  32'h0,        2'b00, 1'b0, 5'd0,  32'h0};

        rst = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", 64'(rf_we), 64'd0);
        chk("reset rf_wa", 64'(rf_wa), 64'd0);
        chk("reset rf_wd", 64'(rf_wd), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset pend_valid", 64'(pend_valid), 64'd0);

        // Release reset with a request already waiting.
        drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        rst = 1'b0;
        #3;
`ifdef REGFILE_CLEAR_EN
        chk("clear start init_done", 64'(init_done), 64'd0);
        chk("clear start ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            #3;
            chk("clear rf_we", 64'(rf_we), 64'd1);
            chk("clear rf_wa", 64'(rf_wa), 64'(i));
            chk("clear rf_wd", 64'(rf_wd), 64'd0);
            chk("clear ready", 64'(req_ready), 64'd0);
            chk("clear init_done", 64'(init_done), 64'd0);
        end
        step();
        #3;
`endif
        chk("init_done after start", 64'(init_done), 64'd1);
        chk("first grant", 64'(req_ready), 64'd1);
        step();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #3;
        chk("first write we", 64'(rf_we), 64'd1);
        chk("first write wa", 64'(rf_wa), 64'd5);
        chk("first write wd", 64'(rf_wd), 64'hDEADBEEF);
        step();

        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].v, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
            #3;
            chk($sformatf("vec%0d ready", r), 64'(req_ready), 64'(tbl[r].rdy));
            chk($sformatf("vec%0d we", r), 64'(rf_we), 64'(tbl[r].we));
            chk($sformatf("vec%0d pend", r), 64'(pend_valid), 64'(tbl[r].we));
            if (tbl[r].we) begin
                chk($sformatf("vec%0d wa", r), 64'(rf_wa), 64'(tbl[r].wa));
                chk($sformatf("vec%0d wd", r), 64'(rf_wd), 64'(tbl[r].wd));
            end
            step();
        end

        // Random traffic; requesters hold their request until granted.
        ptr_m  = 0;
        exp_we = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b0;
            waitc[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int best;
            int bestd;
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom_range(0, 3) != 0)) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
                    pd[i] = $urandom;
                end
                req_valid[i]         = pv[i];
                req_addr[i*AW +: AW] = pa[i];
                req_data[i*DW +: DW] = pd[i];
            end
            #3;
            best  = -1;
            bestd = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                int d;
                d = (i + NREQ - ptr_m) % NREQ;
                if (pv[i] && d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
            chk("rand ready", 64'(req_ready), (best >= 0) ? (64'd1 << best) : 64'd0);
            chk("rand we", 64'(rf_we), 64'(exp_we));
            if (exp_we) begin
                chk("rand wa", 64'(rf_wa), 64'(exp_wa));
                chk("rand wd", 64'(rf_wd), 64'(exp_wd));
            end
            for (int i = 0; i < NREQ; i++) begin
                if (pv[i]) begin
                    waitc[i] = req_ready[i] ? 0 : waitc[i] + 1;
                    chk("rand starvation", 64'(waitc[i] <= NREQ - 1), 64'd1);
                end
            end
            if (best >= 0) begin
                exp_we = (pa[best] != '0);
                if (exp_we) begin
                    exp_wa = pa[best];
                    exp_wd = pd[best];
                end
                pv[best]    = 1'b0;
                waitc[best] = 0;
                ptr_m       = (best + 1) % NREQ;
            end else begin
                exp_we = 1'b0;
            end
            step();
        end

        // Reset while a write of register 7 is on the port.
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        step();
        drive(2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
        #3;
        chk("midflight grant", 64'(req_ready), 64'd1);
        step();
        drive(2'b01, 5'd8, 5'd0, 32'h88, 32'h0);
        #3;
        chk("midflight we before rst", 64'(rf_we), 64'd1);
        chk("midflight wa before rst", 64'(rf_wa), 64'd7);
        rst = 1'b1;
        #1;
        chk("midflight we in rst", 64'(rf_we), 64'd0);
        chk("midflight pend in rst", 64'(pend_valid), 64'd0);
        chk("midflight ready in rst", 64'(req_ready), 64'd0);
        step();
        chk("midflight we held in rst", 64'(rf_we), 64'd0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        #3;
`ifdef REGFILE_CLEAR_EN
        chk("restart clear we", 64'(rf_we), 64'd1);
        chk("restart clear wa", 64'(rf_wa), 64'd0);
        chk("restart clear wd", 64'(rf_wd), 64'd0);
        for (int n = 0; n < 40 && !init_done; n++) begin
            step();
            #3;
        end
        chk("restart init_done", 64'(init_done), 64'd1);
`else
        chk("restart init_done", 64'(init_done), 64'd1);
        chk("restart no write", 64'(rf_we), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (write-enable, write address, write data) between NREQ writeback requesters, e.g. ALU result and load result.
- Uses round-robin valid/ready arbitration and registers the winning write onto the port one cycle later.
- Optionally runs a post-reset clear sequence that zeroes all 32 registers before the datapath may write.
- Sits between the datapath writeback sources and the register file.

Parameters:
- NREQ, 2, number of write requesters (2..4).
- AW, 5, register address width (32 registers).
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  per-requester destination register, packed with requester i at bits [i*AW +: AW].
- req_data  input  NREQ*DW  per-requester write data, packed with requester i at bits [i*DW +: DW].
- req_ready  output  NREQ  per-requester grant, one-hot or zero.
- rf_we  output  1  drives the register file write enable.
- rf_wa  output  AW  drives the register file write address.
- rf_wd  output  DW  drives the register file write data.
- init_done  output  1  high once the block accepts requests.
- pend_valid  output  1  a write is on the port this cycle (copy of rf_we); used by hazard logic.

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_wa=0, rf_wd=0, req_ready=0.
  - Priority pointer = 0.
  - State = CLEAR if REGFILE_CLEAR_EN is defined, else RUN.
  - init_done=0 in CLEAR, 1 in RUN.
- States: CLEAR, RUN.
- CLEAR:
  - 5-bit counter starts at 0.
  - Each cycle: rf_we=1, rf_wa=counter, rf_wd=0, counter+1.
  - After the cycle writing address 31, go to RUN. Exactly 32 write cycles.
  - req_ready=0 throughout; requests are held off, not dropped.
- RUN arbitration (combinational):
  - Search req_valid starting at the pointer index, wrapping modulo NREQ; the first valid requester wins.
  - req_ready = one-hot of the winner, or 0 if none is valid.
  - req_ready never asserts for a requester whose valid is low.
- Transfer occurs on req_valid[i] & req_ready[i] at a clock edge.
- Requester rules:
  - Holds valid, addr and data stable until transfer.
  - May not withdraw valid before transfer.
- Latency: one cycle. The edge after a transfer presents rf_we=1 with rf_wa/rf_wd = the transferred addr/data. The register file captures it on the following edge.
- Cycles with no transfer: rf_we=0; rf_wa/rf_wd hold their previous values.
- Address 0 writes:
  - Handshake completes and the pointer advances normally.
  - rf_we stays 0, so register 0 stays 0 in RUN.
  - CLEAR still writes address 0 with zero.
- Pointer update: after a transfer by requester i, pointer = (i+1) mod NREQ. Unchanged when there is no transfer.
- Throughput: one accepted write per cycle. Back-to-back transfers are allowed with no bubble.
- Simultaneous requests: only the winner transfers; losers keep valid high and win within NREQ-1 cycles (fairness bound).
- Reset mid-operation:
  - Any in-flight write (registered, not yet captured) is cancelled: rf_we=0 immediately.
  - With REGFILE_CLEAR_EN, CLEAR restarts from address 0.
- Reset deassertion: takes effect on the next rising edge.
- NREQ=1: arbitration degenerates to req_ready = valid in RUN; the pointer stays 0.

Optional Feature:
REGFILE_CLEAR_EN.
- Defined: CLEAR state present; the 32-cycle zeroing sequence runs after every reset, and init_done rises on the edge after address 31 is written.
- Undefined: CLEAR logic and counter are omitted; reset goes directly to RUN, and init_done=1 whenever rst=0.

Test Plan:
- Clear sequence (REGFILE_CLEAR_EN defined): release rst, hold req_valid=2'b01 -> rf_we=1 for 32 cycles with rf_wa=0..31 and rf_wd=0; req_ready=0 throughout; init_done=1 afterwards; then the request (addr 5, data 0xDEADBEEF) is granted and appears on rf_wa/rf_wd one cycle later.
- Single write: req0 addr 3, data 0x00000011 -> req_ready=2'b01 the same cycle; next cycle rf_we=1, rf_wa=3, rf_wd=0x11; then rf_we=0.
- Contention: both requesters valid continuously (req0 addr 1 data 0xA, req1 addr 2 data 0xB), pointer=0 -> grants alternate 0,1,0,1; rf_wa sequence 1,2,1,2 with no idle cycles.
- Address 0 drop: req1 addr 0, data 0xFFFFFFFF -> req_ready[1]=1, rf_we stays 0, pointer moves to 0.
- Reset mid-flight: assert rst on the cycle after a transfer of addr 7 -> rf_we=0 immediately, no write to register 7; with clear enabled, rf_wa restarts at 0.
- Fairness: req0 always valid, req1 raises valid once -> req1 granted within 1 cycle; req0 is never starved more than 1 cycle.
